bus_arbiter: RTL and testbench

Round-robin arbiter for the shared unidirectional bus between N `Master` instances and the SDRAM slave. Takes each master's `Req`, returns a one-hot `Ack`, and holds a grant for the master's whole transaction sequence. It releases the grant only at a transfer boundary, then inserts one idle handover cycle. It also drives the slave-side bus by multiplexing the owning master's Control, Address and WData.

---
 rtl/bus_arbiter_pkg.sv | 50 +++++
 rtl/bus_arbiter_if.sv | 49 ++++
 rtl/bus_arbiter_rr_picker.sv | 47 ++++
 rtl/bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bus_pkg
// Description : Shared encodings for the master/SDRAM bus: Control-word field
//               positions, transfer status codes and arbiter state encodings.
//               Imported by the arbiter, its round-robin picker and the bus
//               interface.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    // Bus widths
    localparam int CTRL_W = 9;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Control word layout: [8:7] status, [6:3] burst, [2:1] size, [0] write
    localparam int CTRL_STATUS_HI = 8;
    localparam int CTRL_STATUS_LO = 7;
    localparam int CTRL_BURST_HI  = 6;
    localparam int CTRL_BURST_LO  = 3;
    localparam int CTRL_SIZE_HI   = 2;
    localparam int CTRL_SIZE_LO   = 1;
    localparam int CTRL_WE_BIT    = 0;

    // Transfer status carried in Control[8:7]
    typedef enum logic [1:0] {
        STATUS_START = 2'b00,
        STATUS_CONT  = 2'b01,
        STATUS_IDLE  = 2'b10,
        STATUS_BUSY  = 2'b11
    } status_e;

    // Control word presented to the slave when nobody owns the bus
    localparam logic [CTRL_W-1:0] CTRL_BUS_IDLE = {STATUS_IDLE, 7'b000_0000};

    // Arbiter states
    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_GRANT    = 2'd1,
        ARB_HANDOVER = 2'd2
    } arb_state_e;

    // Extract the status field of a Control word
    function automatic status_e ctrl_status(input logic [CTRL_W-1:0] ctrl);
        return status_e'(ctrl[CTRL_STATUS_HI:CTRL_STATUS_LO]);
    endfunction

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : bus_arbiter_if
// Description : Bundles the request/grant handshake, the packed per-master
//               Control/Address/WData buses and the slave-side bus driven by
//               the arbiter.
//   Req      : per-master bus request          (masters -> arbiter)
//   Ack      : one-hot grant                    (arbiter -> masters)
//   MControl : packed 9-bit Control, master i at [9i+8:9i]
//   MAddress : packed 32-bit Address per master
//   MWData   : packed 32-bit WData per master
//   Ready    : slave ready
//   SControl / SAddress / SWData : bus presented to the slave
//   Owner    : index of current or last owner
//   Overrun  : sticky tenure-violation flag
//   Modports : master = requester/slave environment side, slave = arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    import bus_pkg::*;

    localparam int OWNER_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]        Req;
    logic [NUM_MASTERS-1:0]        Ack;
    logic [CTRL_W*NUM_MASTERS-1:0] MControl;
    logic [ADDR_W*NUM_MASTERS-1:0] MAddress;
    logic [DATA_W*NUM_MASTERS-1:0] MWData;
    logic                          Ready;
    logic [CTRL_W-1:0]             SControl;
    logic [ADDR_W-1:0]             SAddress;
    logic [DATA_W-1:0]             SWData;
    logic [OWNER_W-1:0]            Owner;
    logic                          Overrun;

    modport master (
        output Req, MControl, MAddress, MWData, Ready,
        input  Ack, SControl, SAddress, SWData, Owner, Overrun
    );

    modport slave (
        input  Req, MControl, MAddress, MWData, Ready,
        output Ack, SControl, SAddress, SWData, Owner, Overrun
    );

endinterface : bus_arbiter_if
`default_nettype wire

// File: rtl/bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin selector. The search begins at
//               i_last+1 and wraps modulo NUM_REQ, so i_last itself is the
//               lowest-priority candidate. The first set request wins.
//   i_req    : request vector
//   i_last   : index of the previous winner
//   o_winner : selected index (equals i_last when nothing is requested)
//   o_valid  : at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0]   i_last,
    output logic      [IDX_W-1:0]   o_winner,
    output logic                    o_valid
);

    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;

    // Walk candidates from furthest to nearest; the nearest set request is
    // written last and therefore wins.
    always_comb begin
        o_winner   = i_last;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_cand = int'(i_last) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_cand_idx = IDX_W'(w_cand);
            if (i_req[w_cand_idx]) begin
                o_winner = w_cand_idx;
            end
        end
    end

    assign o_valid = |i_req;

endmodule : rr_picker
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter for the shared bus between NUM_MASTERS
//               masters and the SDRAM slave. A grant is held for the owner's
//               whole transaction sequence and released only at a transfer
//               boundary (owner drops Req, or reports IDLE status with Ready),
//               followed by one dead handover cycle. The slave bus is the
//               owner's Control/Address/WData, selected by registered state.
//   clk     : bus clock, rising edge
//   reset   : asynchronous, active-low
//   bus     : bus_arbiter_if.slave (Req/Ack handshake, master buses, Ready,
//             slave bus, Owner, Overrun)
//   NUM_MASTERS : number of requesters (2..8)
//   MAX_TENURE  : contended-grant cycles before Overrun is flagged
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_TENURE  = 64
) (
    input wire logic     clk,
    input wire logic     reset,
    bus_arbiter_if.slave bus
);

    localparam int OWNER_W = $clog2(NUM_MASTERS);
    localparam int TEN_W   = $clog2(MAX_TENURE + 1);

    localparam logic [OWNER_W-1:0]     OWNER_RST = OWNER_W'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] ACK_ONE   = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [TEN_W-1:0]       TEN_MAX   = TEN_W'(MAX_TENURE);

    // ------------------------------------------------------------------
    // Unpack the per-master buses
    // ------------------------------------------------------------------
    logic [CTRL_W-1:0] w_mctrl [NUM_MASTERS];
    logic [ADDR_W-1:0] w_maddr [NUM_MASTERS];
    logic [DATA_W-1:0] w_mdata [NUM_MASTERS];

    generate
        for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
            assign w_mctrl[g] = bus.MControl[g*CTRL_W +: CTRL_W];
            assign w_maddr[g] = bus.MAddress[g*ADDR_W +: ADDR_W];
            assign w_mdata[g] = bus.MWData[g*DATA_W +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e             state_q,   state_d;
    logic [OWNER_W-1:0]     owner_q,   owner_d;
    logic [NUM_MASTERS-1:0] ack_q,     ack_d;
    logic [TEN_W-1:0]       tenure_q,  tenure_d;
    logic                   overrun_q, overrun_d;

    // ------------------------------------------------------------------
    // Round-robin winner, searched from the last owner + 1
    // ------------------------------------------------------------------
    logic [OWNER_W-1:0] w_pick_idx;
    logic               w_pick_valid;

    rr_picker #(
        .NUM_REQ (NUM_MASTERS),
        .IDX_W   (OWNER_W)
    ) u_rr_picker (
        .i_req    (bus.Req),
        .i_last   (owner_q),
        .o_winner (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // Release at a transfer boundary only: the owner withdraws its request,
    // or it reports IDLE while the slave is ready. BUSY or Ready=0 never
    // release the grant.
    logic w_release;
    logic w_others_req;

    assign w_release    = !bus.Req[owner_q] ||
                          ((ctrl_status(w_mctrl[owner_q]) == STATUS_IDLE) && bus.Ready);
    assign w_others_req = |(bus.Req & ~ack_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ack_d     = ack_q;
        tenure_d  = tenure_q;
        overrun_d = overrun_q;

        case (state_q)
            ARB_IDLE, ARB_HANDOVER: begin
                if (w_pick_valid) begin
                    state_d  = ARB_GRANT;
                    owner_d  = w_pick_idx;
                    ack_d    = ACK_ONE << w_pick_idx;
                    tenure_d = '0;
                end else begin
                    state_d  = ARB_IDLE;
                end
            end

            ARB_GRANT: begin
                // Only contended cycles count towards tenure
                if (w_others_req && (tenure_q != TEN_MAX)) begin
                    tenure_d = tenure_q + TEN_W'(1);
                end
                if (w_release) begin
                    state_d = ARB_HANDOVER;
                    ack_d   = '0;
                end
            end

            default: begin
                state_d = ARB_IDLE;
                ack_d   = '0;
            end
        endcase

        // Sticky: set in the same edge the counter reaches the limit
        if (tenure_d == TEN_MAX) begin
            overrun_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWNER_RST;
            ack_q     <= '0;
            tenure_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ack_q     <= ack_d;
            tenure_q  <= tenure_d;
            overrun_q <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Slave-side bus mux. Selected only by registered state and owner, so
    // Req never reaches the slave bus combinationally, and an asynchronous
    // reset idles the bus immediately.
    // ------------------------------------------------------------------
    always_comb begin
        bus.SControl = CTRL_BUS_IDLE;
        bus.SAddress = '0;
        bus.SWData   = '0;
        if (state_q == ARB_GRANT) begin
            bus.SControl = w_mctrl[owner_q];
            bus.SAddress = w_maddr[owner_q];
            bus.SWData   = w_mdata[owner_q];
        end
    end

    assign bus.Ack     = ack_q;
    assign bus.Owner   = owner_q;
    assign bus.Overrun = overrun_q;

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed self-checking bench for bus_arbiter (4 masters,
//               MAX_TENURE = 8). Expected values are queued when stimulus is
//               driven and popped when the corresponding DUT output is
//               sampled, one cycle step (#1 after the rising edge) later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int N = 4;

    logic clk;
    logic reset;

    bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

    bus_arbiter #(
        .NUM_MASTERS (N),
        .MAX_TENURE  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    string       tag_q [$];
    logic [31:0] exp_q [$];

    // Burst profile for master 1: status and Ready per cycle
    logic [1:0] t3_st  [12] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11,
                                2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    logic       t3_rdy [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int         t2_order [5] = '{0, 1, 2, 3, 0};

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_obs(input logic [31:0] obs);
        string       tag;
        logic [31:0] expv;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h required <none>", obs);
            return;
        end
        tag  = tag_q.pop_front();
        expv = exp_q.pop_front();
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] mk_ctrl(input logic [1:0] st, input logic [3:0] burst,
                                           input logic [1:0] size, input logic we);
        return {st, burst, size, we};
    endfunction

    task automatic set_m(input int i, input logic [8:0] c, input logic [31:0] a,
                         input logic [31:0] d);
        bus.MControl[i*9 +: 9]   = c;
        bus.MAddress[i*32 +: 32] = a;
        bus.MWData[i*32 +: 32]   = d;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        bus.Req   = '0;
        bus.Ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            set_m(i, mk_ctrl(STATUS_START, 4'd0, 2'd0, 1'b0),
                  32'hA000_0000 + 32'(i), 32'hC000_0000 + 32'(i));
        end
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] c;

        // ---------------- Reset state (asynchronous) ----------------
        reset        = 1'b1;
        bus.Req      = '0;
        bus.Ready    = 1'b1;
        bus.MControl = '0;
        bus.MAddress = '0;
        bus.MWData   = '0;
        #2;
        reset = 1'b0;
        sb_push("rst_ack", 32'h0);
        sb_push("rst_sctl", 32'h100);
        sb_push("rst_saddr", 32'h0);
        sb_push("rst_swdata", 32'h0);
        sb_push("rst_owner", 32'h3);
        sb_push("rst_overrun", 32'h0);
        #1;
        check_obs(32'(bus.Ack));
        check_obs(32'(bus.SControl));
        check_obs(bus.SAddress);
        check_obs(bus.SWData);
        check_obs(32'(bus.Owner));
        check_obs(32'(bus.Overrun));

        // ---------------- Single requester, 4-beat write ----------------
        do_reset();
        bus.Req = 4'b0001;
        sb_push("t1_grant", 32'h1);
        step();
        check_obs(32'(bus.Ack));
        for (int b = 0; b < 4; b++) begin
            c = mk_ctrl((b == 0) ? STATUS_START : STATUS_CONT, 4'd3, 2'd2, 1'b1);
            set_m(0, c, 32'h1000_0000 + 32'(b * 4), 32'hD000_0000 + 32'(b));
            set_m(1, mk_ctrl(STATUS_START, 4'd7, 2'd2, 1'b0), 32'hBAD0_0000, 32'hBAD0_0001);
            sb_push("t1_sctl", 32'(c));
            sb_push("t1_saddr", 32'h1000_0000 + 32'(b * 4));
            sb_push("t1_swdata", 32'hD000_0000 + 32'(b));
            #1;
            check_obs(32'(bus.SControl));
            check_obs(bus.SAddress);
            check_obs(bus.SWData);
            step();
        end
        set_m(0, mk_ctrl(STATUS_IDLE, 4'd3, 2'd2, 1'b1), 32'h0, 32'h0);
        bus.Ready = 1'b1;
        sb_push("t1_rel_ack", 32'h0);
        sb_push("t1_rel_sctl", 32'h100);
        step();
        check_obs(32'(bus.Ack));
        check_obs(32'(bus.SControl));
        sb_push("t1_regrant", 32'h1);
        step();
        check_obs(32'(bus.Ack));
        bus.Req = 4'b0000;
        sb_push("t1_drop", 32'h0);
        step();
        check_obs(32'(bus.Ack));

        // ---------------- All request: order 0,1,2,3,0 ----------------
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_m(i, mk_ctrl(STATUS_IDLE, 4'(i + 1), 2'd2, 1'b1),
                  32'h2000_0000 + 32'(i), 32'h0);
        end
        bus.Ready = 1'b1;
        bus.Req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            sb_push("t2_grant", 32'h1 << t2_order[k]);
            sb_push("t2_sctl", 32'(mk_ctrl(STATUS_IDLE, 4'(t2_order[k] + 1), 2'd2, 1'b1)));
            sb_push("t2_gap_ack", 32'h0);
            sb_push("t2_gap_sctl", 32'h100);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            check_obs(32'(bus.Ack));
            check_obs(32'(bus.SControl));
            step();
            check_obs(32'(bus.Ack));
            check_obs(32'(bus.SControl));
        end

        // ---------------- No mid-burst preemption ----------------
        do_reset();
        bus.Ready = 1'b1;
        set_m(2, mk_ctrl(STATUS_START, 4'd1, 2'd2, 1'b1), 32'h3000_0000, 32'h0);
        bus.Req = 4'b0110;
        sb_push("t3_grant", 32'h2);
        step();
        check_obs(32'(bus.Ack));
        for (int k = 0; k < 12; k++) begin
            set_m(1, mk_ctrl(t3_st[k], 4'd8, 2'd2, 1'b1), 32'h4000_0000 + 32'(k), 32'h0);
            bus.Ready = t3_rdy[k];
            sb_push("t3_hold", 32'h2);
            step();
            check_obs(32'(bus.Ack));
        end
        bus.Ready = 1'b1;
        sb_push("t3_rel_ack", 32'h0);
        sb_push("t3_rel_owner", 32'h1);
        step();
        check_obs(32'(bus.Ack));
        check_obs(32'(bus.Owner));
        sb_push("t3_next", 32'h4);
        step();
        check_obs(32'(bus.Ack));

        // ---------------- Req-drop release ----------------
        set_m(2, mk_ctrl(STATUS_CONT, 4'd1, 2'd2, 1'b1), 32'h3000_0004, 32'h0);
        bus.Req = 4'b0010;
        sb_push("t4_rel_ack", 32'h0);
        sb_push("t4_rel_owner", 32'h2);
        step();
        check_obs(32'(bus.Ack));
        check_obs(32'(bus.Owner));
        sb_push("t4_next", 32'h2);
        step();
        check_obs(32'(bus.Ack));

        // ---------------- Overrun (MAX_TENURE = 8) ----------------
        do_reset();
        set_m(0, mk_ctrl(STATUS_CONT, 4'd2, 2'd2, 1'b1), 32'h5000_0000, 32'h0);
        set_m(3, mk_ctrl(STATUS_START, 4'd2, 2'd2, 1'b1), 32'h6000_0000, 32'h0);
        bus.Req = 4'b1001;
        sb_push("t5_grant", 32'h1);
        step();
        check_obs(32'(bus.Ack));
        for (int k = 0; k < 7; k++) begin
            sb_push("t5_hold", 32'h1);
            step();
            check_obs(32'(bus.Ack));
        end
        sb_push("t5_ovr_pre", 32'h0);
        check_obs(32'(bus.Overrun));
        sb_push("t5_ovr_set", 32'h1);
        step();
        check_obs(32'(bus.Overrun));
        step();
        step();
        set_m(0, mk_ctrl(STATUS_IDLE, 4'd2, 2'd2, 1'b1), 32'h5000_0000, 32'h0);
        bus.Ready = 1'b1;
        sb_push("t5_rel_ack", 32'h0);
        sb_push("t5_rel_ovr", 32'h1);
        step();
        check_obs(32'(bus.Ack));
        check_obs(32'(bus.Overrun));
        sb_push("t5_next_ack", 32'h8);
        sb_push("t5_next_ovr", 32'h1);
        step();
        check_obs(32'(bus.Ack));
        check_obs(32'(bus.Overrun));

        // ---------------- Asynchronous reset mid-burst ----------------
        do_reset();
        set_m(0, mk_ctrl(STATUS_START, 4'd4, 2'd2, 1'b1), 32'h7000_0000, 32'h0);
        bus.Req = 4'b0011;
        sb_push("t6_grant", 32'h1);
        step();
        check_obs(32'(bus.Ack));
        set_m(0, mk_ctrl(STATUS_CONT, 4'd4, 2'd2, 1'b1), 32'h7000_0004, 32'h0);
        step();
        #3;
        reset = 1'b0;
        sb_push("t6_rst_ack", 32'h0);
        sb_push("t6_rst_sctl", 32'h100);
        sb_push("t6_rst_owner", 32'h3);
        #1;
        check_obs(32'(bus.Ack));
        check_obs(32'(bus.SControl));
        check_obs(32'(bus.Owner));
        #1;
        reset = 1'b1;
        sb_push("t6_first", 32'h1);
        step();
        check_obs(32'(bus.Ack));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bus_arbiter
`default_nettype wire
